// File: rtl/char_buffer_ctrl.sv
// char_buffer_ctrl: 16x16 text-cell buffer with byte-stream writer, cursor, clear sweep and registered read port.
// Rev 1.0
`default_nettype none

module char_buffer_ctrl #(
   parameter logic [6:0] FILL_CHAR  = 7'h20,
   parameter bit         INIT_CLEAR = 1'b1
) (
   input  logic       clk_in,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       clear_req,
   input  logic [7:0] char_xy,
   output logic [6:0] char_code,
   output logic [7:0] cursor_xy,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_CLEAR_PEND = 2'd1,
      ST_CLEAR      = 2'd2
   } state_t;

   localparam state_t C_RESET_STATE = INIT_CLEAR ? ST_CLEAR_PEND : ST_IDLE;

   state_t     state_q;
   logic [7:0] cursor_q;
   logic [7:0] cnt_q;
   logic       busy_q;
   logic [6:0] char_code_q;

   logic [6:0] mem [256];

   logic       w_we;
   logic [7:0] w_waddr;
   logic [6:0] w_wdata;
   logic [7:0] w_cursor_d;
   logic       w_start_clear;

   assign in_ready  = (state_q == ST_IDLE) && !clear_req;
   assign char_code = char_code_q;
   assign cursor_xy = cursor_q;
   assign busy      = busy_q;

   // Single write port: the sweep owns it in CLEAR, the byte decoder in IDLE.
   always_comb begin
      w_we          = 1'b0;
      w_waddr       = cursor_q;
      w_wdata       = in_data[6:0];
      w_cursor_d    = cursor_q;
      w_start_clear = 1'b0;
      if (state_q == ST_CLEAR) begin
         w_we    = 1'b1;
         w_waddr = cnt_q;
         w_wdata = FILL_CHAR;
      end else if (state_q == ST_IDLE) begin
         if (clear_req) begin
            w_start_clear = 1'b1;
         end else if (in_valid) begin
            if (in_data >= 8'h20 && in_data <= 8'h7E) begin
               w_we       = 1'b1;
               w_cursor_d = cursor_q + 8'd1;
            end else begin
               case (in_data)
                  8'h0D: w_cursor_d = {cursor_q[7:4], 4'h0};
                  8'h0A: w_cursor_d = {cursor_q[7:4] + 4'h1, cursor_q[3:0]};
                  8'h08: begin
                     if (cursor_q != 8'h00) begin
                        w_cursor_d = cursor_q - 8'd1;
                        w_we       = 1'b1;
                        w_waddr    = cursor_q - 8'd1;
                        w_wdata    = FILL_CHAR;
                     end
                  end
                  8'h0C:   w_start_clear = 1'b1;
                  default: w_cursor_d = cursor_q;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_we) begin
         mem[w_waddr] <= w_wdata;
      end
   end

   // The reset state CLEAR_PEND first arms busy, then spends its one busy cycle before CLEAR.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= C_RESET_STATE;
         cursor_q    <= 8'h00;
         cnt_q       <= 8'h00;
         busy_q      <= 1'b0;
         char_code_q <= 7'h00;
      end else begin
         char_code_q <= mem[char_xy];
         case (state_q)
            ST_IDLE: begin
               cursor_q <= w_cursor_d;
               if (w_start_clear) begin
                  state_q <= ST_CLEAR;
                  busy_q  <= 1'b1;
               end
            end
            ST_CLEAR_PEND: begin
               if (!busy_q) begin
                  busy_q <= 1'b1;
               end else begin
                  state_q <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               cnt_q <= cnt_q + 8'd1;
               if (cnt_q == 8'hFF) begin
                  cursor_q <= 8'h00;
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
